// File: rtl/mem_access_stage.sv
// RV32I MEM stage: drives the dcache request/response handshake, steers store bytes onto their
// lanes, aligns and extends load data, and loads the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_dmem_read,
  input  logic                 ex_dmem_write,
  input  logic                 ex_load_regfile,
  input  logic                 ex_wbmux_sel,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_alu_out,
  input  logic [31:0]          ex_rs2,
  input  logic [4:0]           ex_rd,
  output logic [31:0]          dmem_address,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 stall,
  output logic                 wb_valid,
  output logic                 wb_load_regfile,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wmask_q, wmask_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [2:0]           f3_q, f3_d;
  logic [4:0]           rd_q, rd_d;
  logic                 lr_q, lr_d;
  logic                 sel_q, sel_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_lr_q, wb_lr_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 mis_q, mis_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        mem_op, f3_bad, addr_bad, op_dropped;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign mem_op = ex_dmem_read | ex_dmem_write;

  // Unsigned load widths have no store counterpart, so they are illegal on a write.
  always_comb begin
    f3_bad   = 1'b0;
    addr_bad = 1'b0;
    case (ex_funct3)
      3'b000: addr_bad = 1'b0;
      3'b001: addr_bad = ex_alu_out[0];
      3'b010: addr_bad = |ex_alu_out[1:0];
      3'b100: f3_bad = ex_dmem_write;
      3'b101: begin
        f3_bad   = ex_dmem_write;
        addr_bad = ex_alu_out[0];
      end
      default: f3_bad = 1'b1;
    endcase
  end

  assign op_dropped = f3_bad | addr_bad;

  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   st_wmask = 4'b0001 << ex_alu_out[1:0];
      2'b01:   st_wmask = 4'b0011 << ex_alu_out[1:0];
      default: st_wmask = 4'b1111;
    endcase
    if (!ex_dmem_write) st_wmask = 4'b0000;
  end

  assign st_wdata = ex_rs2 << {ex_alu_out[1:0], 3'b000};

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    read_d     = read_q;
    write_d    = write_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    lr_d       = lr_q;
    sel_d      = sel_q;
    wb_valid_d = 1'b0;
    wb_lr_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    stall      = 1'b0;
    case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_lr_d    = ex_load_regfile;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_out;
          end else if (op_dropped) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_out;
            mis_d      = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StAccess;
            addr_d  = ex_alu_out;
            wdata_d = st_wdata;
            wmask_d = st_wmask;
            read_d  = ex_dmem_read;
            write_d = ex_dmem_write;
            f3_d    = ex_funct3;
            rd_d    = ex_rd;
            lr_d    = ex_load_regfile;
            sel_d   = ex_wbmux_sel;
          end
        end
      end
      StAccess: begin
        if (dmem_resp) begin
          state_d    = StIdle;
          read_d     = 1'b0;
          write_d    = 1'b0;
          wb_valid_d = 1'b1;
          wb_lr_d    = lr_q & ~write_q;
          wb_rd_d    = rd_q;
          wb_data_d  = sel_q ? load_val : addr_q;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Upstream must not see a stall while the stage is being reset.
    if (rst) stall = 1'b0;
  end

  assign cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      lr_q       <= 1'b0;
      sel_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_lr_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      read_q     <= read_d;
      write_q    <= write_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      lr_q       <= lr_d;
      sel_q      <= sel_d;
      wb_valid_q <= wb_valid_d;
      wb_lr_q    <= wb_lr_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dmem_address    = {addr_q[31:2], 2'b00};
  assign dmem_read       = read_q;
  assign dmem_write      = write_q;
  assign dmem_wmask      = wmask_q;
  assign dmem_wdata      = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_load_regfile = wb_lr_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign misaligned      = mis_q;
  assign stall_cycles    = cnt_q;

endmodule
